// File: rtl/iob_soc_opencryptolinux_iob_arbiter_if.sv
// Bus bundle around the IOb arbiter: N requester ports plus the single shared slave port.
// Signal suffixes are taken from the arbiter's point of view.
interface iob_soc_opencryptolinux_iob_arbiter_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N_MASTERS = 2
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // requester side
    logic [N_MASTERS-1:0]        m_avalid_i;
    logic [N_MASTERS*ADDR_W-1:0] m_addr_i;
    logic [N_MASTERS*DATA_W-1:0] m_wdata_i;
    logic [N_MASTERS*STRB_W-1:0] m_wstrb_i;
    logic [N_MASTERS-1:0]        m_ready_o;
    logic [N_MASTERS-1:0]        m_rvalid_o;
    logic [DATA_W-1:0]           m_rdata_o;

    // shared slave side
    logic                        s_avalid_o;
    logic [ADDR_W-1:0]           s_addr_o;
    logic [DATA_W-1:0]           s_wdata_o;
    logic [STRB_W-1:0]           s_wstrb_o;
    logic                        s_ready_i;
    logic                        s_rvalid_i;
    logic [DATA_W-1:0]           s_rdata_i;

    // arbiter view
    modport slave (
        input  m_avalid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        output m_ready_o, m_rvalid_o, m_rdata_o,
        output s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o,
        input  s_ready_i, s_rvalid_i, s_rdata_i
    );

    // environment view (requesters and the downstream slave)
    modport master (
        output m_avalid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        input  m_ready_o, m_rvalid_o, m_rdata_o,
        input  s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o,
        output s_ready_i, s_rvalid_i, s_rdata_i
    );
endinterface

// File: rtl/iob_soc_opencryptolinux_iob_arbiter.sv
// Round-robin arbiter sharing one IOb slave port among N_MASTERS requesters.
// One transaction in flight; reads hold the grant until rvalid, writes release on acceptance.
module iob_soc_opencryptolinux_iob_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N_MASTERS = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n_i,
    input  logic                                     cke_i,
    iob_soc_opencryptolinux_iob_arbiter_if.slave     bus,
    output logic [N_MASTERS-1:0]                     grant_o,
    output logic                                     busy_o
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(N_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     sel_q, sel_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     rr_ptr_next;

    logic                 g_avalid;
    logic [ADDR_W-1:0]    g_addr;
    logic [DATA_W-1:0]    g_wdata;
    logic [STRB_W-1:0]    g_wstrb;

    logic                 found;
    logic [PTR_W:0]       cand;
    logic [PTR_W-1:0]     idx;

    assign grant_o     = grant_q;
    assign busy_o      = (state_q != ST_IDLE);
    // the master just served drops to lowest priority
    assign rr_ptr_next = (sel_q == PTR_W'(N_MASTERS - 1)) ? '0 : sel_q + PTR_W'(1);

    // Select the granted master's request fields.
    always_comb begin
        g_avalid = 1'b0;
        g_addr   = '0;
        g_wdata  = '0;
        g_wstrb  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant_q[k]) begin
                g_avalid = bus.m_avalid_i[k];
                g_addr   = bus.m_addr_i[k*ADDR_W +: ADDR_W];
                g_wdata  = bus.m_wdata_i[k*DATA_W +: DATA_W];
                g_wstrb  = bus.m_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    // Next-state, arbitration and bus outputs.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        sel_d          = sel_q;
        rr_ptr_d       = rr_ptr_q;
        found          = 1'b0;
        cand           = '0;
        idx            = '0;
        bus.s_avalid_o = 1'b0;
        bus.s_addr_o   = '0;
        bus.s_wdata_o  = '0;
        bus.s_wstrb_o  = '0;
        bus.m_ready_o  = '0;
        bus.m_rvalid_o = '0;
        bus.m_rdata_o  = '0;

        case (state_q)
            ST_IDLE: begin
                // first requester at or above rr_ptr, wrapping
                for (int unsigned i = 0; i < N_MASTERS; i++) begin
                    cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
                    if (cand >= (PTR_W+1)'(N_MASTERS)) begin
                        cand = cand - (PTR_W+1)'(N_MASTERS);
                    end
                    idx = cand[PTR_W-1:0];
                    if (!found && bus.m_avalid_i[idx]) begin
                        found        = 1'b1;
                        grant_d      = '0;
                        grant_d[idx] = 1'b1;
                        sel_d        = idx;
                    end
                end
                if (found) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.s_avalid_o = g_avalid;
                bus.s_addr_o   = g_addr;
                bus.s_wdata_o  = g_wdata;
                bus.s_wstrb_o  = g_wstrb;
                bus.m_ready_o  = grant_q & {N_MASTERS{bus.s_ready_i & g_avalid}};
                if (!g_avalid) begin
                    // requester withdrew before acceptance: drop it, keep priority
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (bus.s_ready_i) begin
                    if (|g_wstrb) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = rr_ptr_next;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                bus.m_rvalid_o = grant_q & {N_MASTERS{bus.s_rvalid_i}};
                bus.m_rdata_o  = bus.s_rdata_i;
                if (bus.s_rvalid_i) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = rr_ptr_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers: synchronous reset wins over the clock enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_iob_soc_opencryptolinux_iob_arbiter.sv
// Self-checking bench for the IOb round-robin arbiter (2 masters, 32-bit bus).
module tb_iob_soc_opencryptolinux_iob_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NM     = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  mst;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mst;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cke;
    logic [NM-1:0] grant;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    req_t req_q[$];
    rsp_t rsp_q[$];

    iob_soc_opencryptolinux_iob_arbiter_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_MASTERS(NM)
    ) bus ();

    iob_soc_opencryptolinux_iob_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_MASTERS(NM)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cke_i   (cke),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_m(input int k, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bus.m_avalid_i[k]        = v;
        bus.m_addr_i[k*32 +: 32] = a;
        bus.m_wdata_i[k*32 +: 32] = d;
        bus.m_wstrb_i[k*4 +: 4]  = s;
    endtask

    task automatic drv_s(input logic rdy, input logic rv, input logic [31:0] rd);
        bus.s_ready_i  = rdy;
        bus.s_rvalid_i = rv;
        bus.s_rdata_i  = rd;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] m);
        req_t r;
        r.addr = a; r.wdata = d; r.wstrb = s; r.mst = m;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic [1:0] m);
        rsp_t r;
        r.data = d; r.mst = m;
        rsp_q.push_back(r);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},   64'(busy), 64'd0);
        check({tag, "_grant"},  64'(grant), 64'd0);
        check({tag, "_savalid"}, 64'(bus.s_avalid_o), 64'd0);
        check({tag, "_mrvalid"}, 64'(bus.m_rvalid_o), 64'd0);
        check({tag, "_mrdata"},  64'(bus.m_rdata_o), 64'd0);
    endtask

    // Scoreboard: compare every slave handshake and every read response mid-cycle.
    always @(negedge clk) begin
        req_t er;
        rsp_t es;
        if (bus.s_avalid_o && bus.s_ready_i) begin
            if (req_q.size() == 0) begin
                check("sb_unexpected_req", 64'(bus.s_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                er = req_q.pop_front();
                check("sb_addr",  64'(bus.s_addr_o),  64'(er.addr));
                check("sb_wdata", 64'(bus.s_wdata_o), 64'(er.wdata));
                check("sb_wstrb", 64'(bus.s_wstrb_o), 64'(er.wstrb));
                check("sb_grant", 64'(grant), 64'(2'b01 << er.mst));
                check("sb_mready", 64'(bus.m_ready_o), 64'(2'b01 << er.mst));
            end
        end
        if (|bus.m_rvalid_o) begin
            if (rsp_q.size() == 0) begin
                check("sb_unexpected_rvalid", 64'(bus.m_rvalid_o), 64'd0);
            end else begin
                es = rsp_q.pop_front();
                check("sb_rdata",  64'(bus.m_rdata_o), 64'(es.data));
                check("sb_rvalid", 64'(bus.m_rvalid_o), 64'(2'b01 << es.mst));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cke   = 1'b1;
        bus.m_avalid_i = '0;
        bus.m_addr_i   = '0;
        bus.m_wdata_i  = '0;
        bus.m_wstrb_i  = '0;
        drv_s(1'b0, 1'b0, 32'h0);
        step();
        step();
        check_quiet("reset");
        check("reset_mready", 64'(bus.m_ready_o), 64'd0);
        rst_n = 1'b1;

        // Contention: both masters keep writing, slave always ready.
        drv_m(0, 1'b1, 32'h4, 32'hA0A0_0000, 4'hF);
        drv_m(1, 1'b1, 32'h8, 32'hB1B1_1111, 4'hF);
        drv_s(1'b1, 1'b0, 32'h0);
        push_req(32'h4, 32'hA0A0_0000, 4'hF, 2'd0);
        push_req(32'h8, 32'hB1B1_1111, 4'hF, 2'd1);
        push_req(32'h4, 32'hA0A0_0000, 4'hF, 2'd0);
        push_req(32'h8, 32'hB1B1_1111, 4'hF, 2'd1);
        #1;
        check("cont_idle_savalid", 64'(bus.s_avalid_o), 64'd0);
        check("cont_idle_mready",  64'(bus.m_ready_o), 64'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            #1;
            if (i % 2 == 1) begin
                check("cont_req_grant", 64'(grant), (i % 4 == 1) ? 64'd1 : 64'd2);
            end else begin
                check("cont_idle_savalid", 64'(bus.s_avalid_o), 64'd0);
            end
        end
        step();
        drv_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_s(1'b0, 1'b0, 32'h0);
        #1;
        check_quiet("cont_end");

        // Single read by master0.
        step();
        drv_m(0, 1'b1, 32'h10, 32'h0, 4'h0);
        push_req(32'h10, 32'h0, 4'h0, 2'd0);
        #1;
        check("rd_idle_mready", 64'(bus.m_ready_o), 64'd0);
        step();
        drv_s(1'b1, 1'b0, 32'h0);
        #1;
        check("rd_mready", 64'(bus.m_ready_o), 64'd1);
        step();
        drv_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_s(1'b0, 1'b1, 32'hDEAD_BEEF);
        push_rsp(32'hDEAD_BEEF, 2'd0);
        #1;
        check("rd_rvalid", 64'(bus.m_rvalid_o), 64'd1);
        check("rd_rdata",  64'(bus.m_rdata_o), 64'hDEAD_BEEF);
        check("rd_savalid", 64'(bus.s_avalid_o), 64'd0);
        step();
        drv_s(1'b0, 1'b0, 32'h0);
        #1;
        check_quiet("rd_done");

        // Write release by master1.
        drv_m(1, 1'b1, 32'h20, 32'h5555_AAAA, 4'hF);
        push_req(32'h20, 32'h5555_AAAA, 4'hF, 2'd1);
        step();
        drv_s(1'b1, 1'b0, 32'h0);
        #1;
        check("wr_grant", 64'(grant), 64'd2);
        step();
        drv_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_s(1'b0, 1'b0, 32'h0);
        #1;
        check_quiet("wr_release");

        // Slave stall with both masters pending; rr_ptr is back at master0.
        drv_m(0, 1'b1, 32'h30, 32'h0000_1234, 4'h3);
        drv_m(1, 1'b1, 32'h40, 32'h0000_5678, 4'hF);
        push_req(32'h30, 32'h0000_1234, 4'h3, 2'd0);
        push_req(32'h40, 32'h0000_5678, 4'hF, 2'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            drv_s(i == 4, 1'b0, 32'h0);
            #1;
            check("stall_savalid", 64'(bus.s_avalid_o), 64'd1);
            check("stall_addr",    64'(bus.s_addr_o), 64'h30);
            check("stall_wdata",   64'(bus.s_wdata_o), 64'h1234);
            check("stall_mready",  64'(bus.m_ready_o), (i == 4) ? 64'd1 : 64'd0);
        end
        step();
        drv_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_s(1'b1, 1'b0, 32'h0);
        step();
        step();
        drv_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_s(1'b0, 1'b0, 32'h0);
        #1;
        check_quiet("stall_done");

        // Reset mid-read: the late rvalid must be ignored.
        drv_m(0, 1'b1, 32'h50, 32'h0, 4'h0);
        push_req(32'h50, 32'h0, 4'h0, 2'd0);
        step();
        drv_s(1'b1, 1'b0, 32'h0);
        step();
        drv_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_s(1'b0, 1'b0, 32'h0);
        #1;
        check("rst_rdwait_busy", 64'(busy), 64'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drv_s(1'b0, 1'b1, 32'h1357_9BDF);
        #1;
        check_quiet("rst_midread");
        step();
        drv_s(1'b0, 1'b0, 32'h0);

        // cke freeze in RDWAIT by master1.
        drv_m(1, 1'b1, 32'h60, 32'h0, 4'h0);
        push_req(32'h60, 32'h0, 4'h0, 2'd1);
        step();
        drv_s(1'b1, 1'b0, 32'h0);
        step();
        drv_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        drv_s(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            cke = 1'b0;
            #1;
            check("cke_busy",   64'(busy), 64'd1);
            check("cke_grant",  64'(grant), 64'd2);
            check("cke_rvalid", 64'(bus.m_rvalid_o), 64'd0);
        end
        step();
        cke = 1'b1;
        drv_s(1'b0, 1'b1, 32'hCAFE_F00D);
        push_rsp(32'hCAFE_F00D, 2'd1);
        #1;
        check("cke_resume_rvalid", 64'(bus.m_rvalid_o), 64'd2);
        step();
        drv_s(1'b0, 1'b0, 32'h0);
        #1;
        check_quiet("cke_done");

        step();
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/iob_soc_opencryptolinux_iob_arbiter.md
Name: iob_soc_opencryptolinux_iob_arbiter

Overview:
- Round-robin arbiter that shares one IOb-native slave port among N_MASTERS IOb-native requesters.
- Target use: the peripheral IOb bus, where the AXI-Lite bridge and auxiliary masters (debug or DMA) contend for the split/peripheral tree.
- One transaction is in flight at a time.
- A read holds the grant until its response returns; a write releases the grant on slave acceptance.

Parameters:
- ADDR_W, 32, IOb address width.
- DATA_W, 32, IOb data width; the wstrb width is DATA_W/8.
- N_MASTERS, 2, number of requesters; legal range 2..8.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; one clock, synchronous, active-low.
- cke_i  in  1  clock enable; when 0, all state holds.
- m_avalid_i  in  N_MASTERS  per-master request valid.
- m_addr_i  in  N_MASTERS*ADDR_W  packed addresses; master k at [k*ADDR_W+:ADDR_W].
- m_wdata_i  in  N_MASTERS*DATA_W  packed write data.
- m_wstrb_i  in  N_MASTERS*DATA_W/8  packed strobes; all-zero means read.
- m_ready_o  out  N_MASTERS  per-master request accepted.
- m_rvalid_o  out  N_MASTERS  per-master read data valid.
- m_rdata_o  out  DATA_W  read data, broadcast to all masters.
- s_avalid_o  out  1  slave request valid.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_wstrb_o  out  DATA_W/8  slave strobes.
- s_ready_i  in  1  slave accepted the request.
- s_rvalid_i  in  1  slave read data valid.
- s_rdata_i  in  DATA_W  slave read data.
- grant_o  out  N_MASTERS  one-hot current grant; zero when IDLE.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge, regardless of cke_i):
  - state=IDLE, rr_ptr=0, grant=0.
  - All outputs 0; m_rdata_o=0.
- All register updates occur only when cke_i=1; reset takes priority over cke_i.
- FSM states: IDLE, REQ, RDWAIT.
- IDLE:
  - If any m_avalid_i bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo N_MASTERS.
  - Register the selection into grant and go to REQ.
  - No request is forwarded in IDLE: s_avalid_o=0 and m_ready_o=0.
- REQ:
  - s_avalid_o = m_avalid_i[g].
  - s_addr_o, s_wdata_o and s_wstrb_o are combinationally muxed from master g.
  - m_ready_o[g] = s_ready_i & m_avalid_i[g]; all other m_ready_o bits are 0.
  - Request handshake: s_avalid_o & s_ready_i in the same cycle.
  - On handshake with wstrb != 0 (write): go to IDLE; rr_ptr = (g+1) mod N_MASTERS.
  - On handshake with wstrb == 0 (read): go to RDWAIT.
  - If m_avalid_i[g] drops before handshake (protocol violation): go to IDLE with rr_ptr unchanged.
- RDWAIT:
  - s_avalid_o=0.
  - m_rvalid_o[g] = s_rvalid_i; m_rdata_o = s_rdata_i (combinational pass-through).
  - On s_rvalid_i: go to IDLE; rr_ptr = (g+1) mod N_MASTERS.
  - s_rvalid_i arriving in the same cycle as the read handshake in REQ is not supported; the slave returns rvalid at least 1 cycle after ready.
- m_rdata_o is 0 outside RDWAIT.
- Latency:
  - Request to slave: 1 cycle after master avalid is first seen in IDLE.
  - Minimum read, idle to idle: 3 cycles (IDLE, REQ with ready=1, RDWAIT with rvalid=1).
  - Minimum write: 2 cycles.
- Fairness: a master that has just been served has the lowest priority in the next arbitration. With N continuously requesting masters, each is granted once every N transactions.
- m_rvalid_i or s_rvalid_i seen in IDLE or REQ is ignored; no output is produced.
- Reset during REQ or RDWAIT: the transaction is abandoned and the FSM returns to IDLE; a late s_rvalid_i is then ignored.
- cke_i=0:
  - FSM, grant and rr_ptr freeze.
  - Combinational outputs still reflect the frozen state and the current inputs.

Test Plan:
- Single read:
  - Stimulus: master0 read, addr 0x10, s_ready_i=1 in cycle 1, s_rvalid_i=1 with 0xDEADBEEF in cycle 2.
  - Response: m_ready_o=01 in cycle 1; m_rvalid_o=01 and m_rdata_o=0xDEADBEEF in cycle 2; busy_o low in cycle 3.
- Contention:
  - Stimulus: both masters hold writes continuously (m0 addr 0x4, m1 addr 0x8); slave always ready.
  - Response: s_addr_o handshakes alternate 0x4, 0x8, 0x4, 0x8; grant_o alternates 01, 10; first grant goes to master0.
- Write release:
  - Stimulus: master1 write with wstrb=0xF.
  - Response: returns to IDLE the cycle after the handshake without waiting for s_rvalid_i; rr_ptr=0.
- Slave stall:
  - Stimulus: s_ready_i held low for 4 REQ cycles.
  - Response: s_avalid_o high and addr/wdata stable for all 5 cycles; m_ready_o asserts only on the 5th.
- Reset mid-read:
  - Stimulus: rst_n_i=0 for 1 cycle in RDWAIT, then s_rvalid_i=1.
  - Response: all outputs 0 after the edge; no m_rvalid_o pulse; grant_o=0.
- cke freeze:
  - Stimulus: cke_i=0 for 3 cycles in RDWAIT with s_rvalid_i=0, then cke_i=1 with s_rvalid_i=1.
  - Response: state holds RDWAIT during the freeze; completes normally after.
